// File: rtl/proc_mem.sv
// Unified instruction/data memory with a byte-stream program loader.
// Holds the processor in reset while loading, then serves imem/dmem accesses.
module proc_mem #(
  parameter int unsigned NUM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         imemreq_val,
  input  logic [31:0]                  imemreq_addr,
  output logic [31:0]                  imemresp_data,
  input  logic                         dmemreq_val,
  input  logic                         dmemreq_type,
  input  logic [31:0]                  dmemreq_addr,
  input  logic [31:0]                  dmemreq_wdata,
  output logic [31:0]                  dmemresp_rdata,
  input  logic                         load_val,
  output logic                         load_rdy,
  input  logic [7:0]                   load_byte,
  input  logic                         load_last,
  output logic                         proc_rst,
  output logic [$clog2(NUM_WORDS):0]   load_count
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {LOAD, RUN} state_t;

  state_t        state;
  logic [AW-1:0] load_ptr;
  logic [1:0]    byte_cnt;
  logic [31:0]   partial;
  logic [31:0]   word;
  logic          accept;
  logic          word_done;

  logic [AW-1:0] iidx;
  logic [AW-1:0] didx;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  logic [31:0]   mem [NUM_WORDS];

  // Only the word-index bits of each address select a location; the rest alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imemreq_addr[31:AW+2], imemreq_addr[1:0],
                              dmemreq_addr[31:AW+2], dmemreq_addr[1:0]};

  assign iidx      = imemreq_addr[AW+1:2];
  assign didx      = dmemreq_addr[AW+1:2];
  assign load_rdy  = (state == LOAD);
  assign accept    = (state == LOAD) && load_val;
  assign word_done = accept && ((byte_cnt == 2'd3) || load_last);

  // Partial word is cleared after each write, so unfilled upper lanes stay zero.
  assign word = partial | ({24'd0, load_byte} << {byte_cnt, 3'b000});

  assign imemresp_data  = ((state == RUN) && imemreq_val) ? mem[iidx] : '0;
  assign dmemresp_rdata = ((state == RUN) && dmemreq_val && !dmemreq_type) ? mem[didx] : '0;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (word_done) begin
      we    = 1'b1;
      waddr = load_ptr;
      wdata = word;
    end else if ((state == RUN) && dmemreq_val && dmemreq_type) begin
      we    = 1'b1;
      waddr = didx;
      wdata = dmemreq_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      load_ptr   <= '0;
      byte_cnt   <= '0;
      partial    <= '0;
      load_count <= '0;
      proc_rst   <= 1'b1;
    end else if (accept) begin
      if (word_done) begin
        partial  <= '0;
        byte_cnt <= '0;
        load_ptr <= load_ptr + AW'(1);
        if (load_count != CW'(NUM_WORDS)) begin
          load_count <= load_count + CW'(1);
        end
        if (load_last) begin
          state    <= RUN;
          proc_rst <= 1'b0;
        end
      end else begin
        partial  <= word;
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_proc_mem.sv
// Scoreboard bench for proc_mem: stimulus pushes expectations, a negedge
// monitor pops and compares whenever a read port or status probe is active.
`timescale 1ns/1ps
module tb_proc_mem;

  logic        clk;
  logic        rst;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic        load_val;
  logic        load_rdy;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        proc_rst;
  logic [8:0]  load_count;

  proc_mem #(.NUM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
    .load_val(load_val), .load_rdy(load_rdy), .load_byte(load_byte), .load_last(load_last),
    .proc_rst(proc_rst), .load_count(load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] sq[$];
  string       in_q[$];
  string       dn_q[$];
  string       sn_q[$];
  logic        stat_chk = 1'b0;

  logic [31:0] ref_mem [256];
  logic [7:0]  prog[$];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void underflow(string nm);
    checks++;
    errors++;
    $display("FAIL %s got output with no expectation queued expected queued entry", nm);
  endfunction

  always @(negedge clk) begin
    if (imemreq_val) begin
      if (iq.size() == 0) underflow("imem");
      else check(in_q.pop_front(), imemresp_data, iq.pop_front());
    end
    if (dmemreq_val && !dmemreq_type) begin
      if (dq.size() == 0) underflow("dmem");
      else check(dn_q.pop_front(), dmemresp_rdata, dq.pop_front());
    end
    if (stat_chk) begin
      if (sq.size() == 0) underflow("status");
      else check(sn_q.pop_front(), {21'd0, load_rdy, proc_rst, load_count}, sq.pop_front());
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int sat(int n);
    return (n > 256) ? 256 : n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_stat(input bit rdy, input bit prst, input int cnt, input string nm);
    stat_chk = 1'b1;
    sq.push_back({21'd0, rdy, prst, 9'(cnt)});
    sn_q.push_back(nm);
    step();
    stat_chk = 1'b0;
  endtask

  task automatic rd_i(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    imemreq_val = 1'b1; imemreq_addr = addr;
    iq.push_back(exp); in_q.push_back(nm);
    step();
    imemreq_val = 1'b0;
  endtask

  task automatic rd_d(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = addr;
    dq.push_back(exp); dn_q.push_back(nm);
    step();
    dmemreq_val = 1'b0;
  endtask

  task automatic wr_d(input logic [31:0] addr, input logic [31:0] data);
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = addr; dmemreq_wdata = data;
    step();
    dmemreq_val = 1'b0; dmemreq_type = 1'b0;
    ref_mem[addr[9:2]] = data;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    exp_stat(1'b1, 1'b1, 0, "reset_hold");
    rst = 1'b1;
    step();
  endtask

  // Streams the first n_send bytes of prog; idle gaps probe LOAD-mode outputs.
  task automatic load_stream(input int n_send, input int max_gap, input bit poke);
    int n;
    int nw;
    int g;
    logic [31:0] w32;
    n = prog.size();
    for (int i = 0; i < n_send; i++) begin
      g = $urandom_range(max_gap, 0);
      repeat (g) begin
        imemreq_val = 1'b1; imemreq_addr = $urandom;
        iq.push_back(32'h0); in_q.push_back("imem_in_load");
        exp_stat(1'b1, 1'b1, sat(i / 4), "load_gap_status");
        imemreq_val = 1'b0;
      end
      load_val = 1'b1; load_byte = prog[i]; load_last = (i == n - 1);
      if (poke) begin
        dmemreq_val = 1'b1; dmemreq_type = 1'b1;
        dmemreq_addr = 32'h8; dmemreq_wdata = 32'hBAD0BAD0;
      end
      step();
      load_val = 1'b0; load_last = 1'b0; dmemreq_val = 1'b0; dmemreq_type = 1'b0;
    end
    nw = (n_send == n) ? (n + 3) / 4 : n_send / 4;
    for (int w = 0; w < nw; w++) begin
      w32 = '0;
      for (int l = 0; l < 4; l++)
        if (4 * w + l < n_send) w32[8*l +: 8] = prog[4 * w + l];
      ref_mem[w % 256] = w32;
    end
    if (n_send == n) exp_stat(1'b0, 1'b0, sat(nw), "run_entry");
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    rst = 1'b0; imemreq_val = 0; imemreq_addr = 0; dmemreq_val = 0; dmemreq_type = 0;
    dmemreq_addr = 0; dmemreq_wdata = 0; load_val = 0; load_byte = 0; load_last = 0;
    step();
    imemreq_val = 1'b1; imemreq_addr = 32'h4; iq.push_back(32'h0); in_q.push_back("imem_reset");
    dmemreq_val = 1'b1; dmemreq_addr = 32'h4; dq.push_back(32'h0); dn_q.push_back("dmem_reset");
    exp_stat(1'b1, 1'b1, 0, "reset_state");
    imemreq_val = 1'b0; dmemreq_val = 1'b0;
    rst = 1'b1;
    step();

    prog = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    load_stream(8, 0, 0);
    rd_i(32'h4, 32'h0000006F, "boot_imem_word1");
    rd_i(32'h0, 32'h00000513, "boot_imem_word0");

    pulse_reset();
    prog = '{8'hAA, 8'hBB};
    load_stream(2, 0, 0);
    rd_d(32'h0, 32'h0000BBAA, "short_last_word");

    wr_d(32'h10, 32'h11111111);
    wr_d(32'h8, 32'hCAFEF00D);
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h10; dmemreq_wdata = 32'hDEADBEEF;
    imemreq_val = 1'b1; imemreq_addr = 32'h10;
    iq.push_back(32'h11111111); in_q.push_back("same_cycle_old");
    step();
    ref_mem[4] = 32'hDEADBEEF;
    dmemreq_type = 1'b0; dmemreq_addr = 32'h10;
    dq.push_back(32'hDEADBEEF); dn_q.push_back("dmem_after_write");
    iq.push_back(32'hDEADBEEF); in_q.push_back("imem_after_write");
    step();
    dmemreq_val = 1'b0; imemreq_val = 1'b0;

    wr_d(32'h400, 32'h12345678);
    rd_d(32'h000, 32'h12345678, "alias_dmem");
    rd_i(32'hFFFFFC00, 32'h12345678, "alias_imem");

    pulse_reset();
    prog = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h90};
    load_stream(6, 1, 0);
    rst = 1'b0;
    exp_stat(1'b1, 1'b1, 0, "mid_load_reset");
    rst = 1'b1;
    step();
    load_stream(8, 3, 1);
    rd_i(32'h0, 32'h12345678, "reload_word0");
    rd_i(32'h4, 32'h90ABCDEF, "reload_word1");
    rd_d(32'h8, 32'hCAFEF00D, "load_ignores_dmem_write");

    pulse_reset();
    prog.delete();
    for (int i = 0; i < 1040; i++) prog.push_back(8'($urandom));
    load_stream(1040, 2, 0);
    for (int i = 0; i < 256; i++) begin
      a = $urandom;
      a[9:2] = 8'(i);
      rd_i(a, ref_mem[i], "full_load_word");
    end

    for (int k = 0; k < 300; k++) begin
      a = $urandom;
      b = ($urandom_range(3, 0) == 0) ? a : $urandom;
      d = $urandom;
      imemreq_val = 1'b1; imemreq_addr = b;
      iq.push_back(ref_mem[b[9:2]]); in_q.push_back("rand_imem");
      dmemreq_val = 1'b1; dmemreq_addr = a;
      if ($urandom_range(1, 0) == 1) begin
        dmemreq_type = 1'b1; dmemreq_wdata = d;
        step();
        ref_mem[a[9:2]] = d;
      end else begin
        dmemreq_type = 1'b0;
        dq.push_back(ref_mem[a[9:2]]); dn_q.push_back("rand_dmem");
        step();
      end
      imemreq_val = 1'b0; dmemreq_val = 1'b0; dmemreq_type = 1'b0;
    end
    exp_stat(1'b0, 1'b0, 256, "run_status_final");

    step();
    check("queues_drained", 32'(iq.size() + dq.size() + sq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
